// File: rtl/rx_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : rx_unpack
//  Purpose  : Parses Ethernet/IPv4/UDP frames arriving as 16-bit big-endian
//             words. It filters on local MAC, IP and UDP port, verifies the
//             IPv4 header checksum and forwards only the UDP payload. The
//             payload leaves with one cycle of latency and with backpressure.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             cfg_mac_l/cfg_ip/cfg_port     - local addressing
//             din*, din_rdy                 - frame word input stream
//             dout*, dout_rdy               - payload word output stream
//             pkt_sip, pkt_sport            - source of current packet
//             good_cnt, drop_cnt            - delivered / discarded frames
//  Revision : 1.0 - initial release
// ============================================================================
module rx_unpack #(
    parameter int BCAST_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] cfg_mac_l,
    input  logic [31:0] cfg_ip,
    input  logic [15:0] cfg_port,
    input  logic [15:0] din,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic        din_vld,
    input  logic        din_mty,
    output logic        din_rdy,
    output logic [15:0] dout,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_vld,
    output logic        dout_mty,
    output logic        dout_err,
    input  logic        dout_rdy,
    output logic [31:0] pkt_sip,
    output logic [15:0] pkt_sport,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_hdr     = 3'd1;
    localparam logic [2:0] c_st_payload = 3'd2;
    localparam logic [2:0] c_st_pad     = 3'd3;
    localparam logic [2:0] c_st_drop    = 3'd4;
    localparam logic [4:0] c_last_hdr   = 5'd20;

    logic [2:0]  r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_rem;
    logic        r_first;
    logic        r_uc;
    logic        r_bc;
    logic [15:0] r_csum;
    logic [31:0] r_sip_tmp;
    logic [15:0] r_sport_tmp;
    logic [15:0] r_udp_len;

    logic        w_acc;
    logic [4:0]  w_idx;
    logic [15:0] w_mac_word;
    logic        w_uc_nxt;
    logic        w_bc_nxt;
    logic [15:0] w_csum_base;
    logic [16:0] w_csum_sum;
    logic [15:0] w_csum_nxt;
    logic        w_fail;
    logic        w_hdr_word;

    logic [2:0]  w_state_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [15:0] w_rem_nxt;
    logic        w_first_nxt;
    logic        w_start;
    logic        w_latch_pkt;
    logic        w_ovld;
    logic        w_osop;
    logic        w_oeop;
    logic        w_omty;
    logic        w_oerr;
    logic [15:0] w_odata;
    logic        w_good_inc;
    logic        w_drop_abort;
    logic        w_drop_start;

    // Only the payload phase is coupled to the downstream; every other phase
    // swallows words freely.
    assign din_rdy = (r_state != c_st_payload) || dout_rdy;
    assign w_acc   = din_vld && din_rdy;

    // A word carrying din_sop is always treated as header word 0.
    assign w_idx = din_sop ? 5'd0 : r_cnt;

    always_comb begin
        case (w_idx)
            5'd0:    w_mac_word = cfg_mac_l[47:32];
            5'd1:    w_mac_word = cfg_mac_l[31:16];
            default: w_mac_word = cfg_mac_l[15:0];
        endcase
    end

    // Unicast and broadcast matches are tracked separately across the three
    // destination words; the frame fails only when neither survives.
    assign w_uc_nxt = ((w_idx == 5'd0) || r_uc) && (din == w_mac_word);
    assign w_bc_nxt = (BCAST_EN != 0) && ((w_idx == 5'd0) || r_bc) && (din == 16'hFFFF);

    // Running ones-complement sum over the IPv4 header, restarted at word 7.
    assign w_csum_base = (w_idx == 5'd7) ? 16'h0000 : r_csum;
    assign w_csum_sum  = {1'b0, w_csum_base} + {1'b0, din};
    assign w_csum_nxt  = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};

    always_comb begin
        w_fail = 1'b0;
        case (w_idx)
            5'd0, 5'd1, 5'd2: w_fail = !(w_uc_nxt || w_bc_nxt);
            5'd6:    w_fail = (din != 16'h0800);
            5'd7:    w_fail = (din[15:8] != 8'h45);
            5'd10:   w_fail = din[13] || (din[12:0] != 13'd0);
            5'd11:   w_fail = (din[7:0] != 8'h11);
            5'd15:   w_fail = (din != cfg_ip[31:16]);
            5'd16:   w_fail = (din != cfg_ip[15:0]) || (w_csum_nxt != 16'hFFFF);
            5'd18:   w_fail = (din != cfg_port);
            5'd19:   w_fail = (din < 16'd9);
            default: w_fail = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_first_nxt  = r_first;
        w_start      = 1'b0;
        w_latch_pkt  = 1'b0;
        w_ovld       = 1'b0;
        w_osop       = 1'b0;
        w_oeop       = 1'b0;
        w_omty       = 1'b0;
        w_oerr       = 1'b0;
        w_odata      = din;
        w_good_inc   = 1'b0;
        w_drop_abort = 1'b0;
        w_drop_start = 1'b0;
        if (w_acc) begin
            case (r_state)
                c_st_idle: begin
                    w_start = din_sop;
                end
                c_st_hdr: begin
                    if (din_sop) begin
                        w_drop_abort = 1'b1;
                        w_start      = 1'b1;
                    end else if (din_eop) begin
                        w_drop_abort = 1'b1;
                        w_state_nxt  = c_st_idle;
                        w_cnt_nxt    = 5'd0;
                    end else if (w_fail) begin
                        w_state_nxt = c_st_drop;
                        w_cnt_nxt   = 5'd0;
                    end else if (r_cnt == c_last_hdr) begin
                        w_state_nxt = c_st_payload;
                        w_cnt_nxt   = 5'd0;
                        w_rem_nxt   = r_udp_len - 16'd8;
                        w_first_nxt = 1'b1;
                        w_latch_pkt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
                c_st_payload: begin
                    w_ovld = 1'b1;
                    if (din_sop) begin
                        // Close the interrupted packet with an error marker.
                        w_odata      = 16'h0000;
                        w_oeop       = 1'b1;
                        w_oerr       = 1'b1;
                        w_drop_abort = 1'b1;
                        w_start      = 1'b1;
                    end else begin
                        w_osop      = r_first;
                        w_first_nxt = 1'b0;
                        if (r_rem <= 16'd2) begin
                            w_oeop      = 1'b1;
                            w_omty      = (r_rem == 16'd1);
                            w_good_inc  = 1'b1;
                            w_state_nxt = din_eop ? c_st_idle : c_st_pad;
                        end else if (din_eop) begin
                            w_oeop       = 1'b1;
                            w_oerr       = 1'b1;
                            w_omty       = din_mty;
                            w_drop_abort = 1'b1;
                            w_state_nxt  = c_st_idle;
                        end else begin
                            w_rem_nxt = r_rem - 16'd2;
                        end
                    end
                end
                c_st_pad: begin
                    if (din_sop) begin
                        w_start = 1'b1;
                    end else if (din_eop) begin
                        w_state_nxt = c_st_idle;
                    end
                end
                c_st_drop: begin
                    if (din_sop) begin
                        w_drop_abort = 1'b1;
                        w_start      = 1'b1;
                    end else if (din_eop) begin
                        w_drop_abort = 1'b1;
                        w_state_nxt  = c_st_idle;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = 5'd0;
                end
            endcase

            // New frame begins with this word as header word 0.
            if (w_start) begin
                w_first_nxt = 1'b0;
                if (din_eop) begin
                    w_drop_start = 1'b1;
                    w_state_nxt  = c_st_idle;
                    w_cnt_nxt    = 5'd0;
                end else if (w_fail) begin
                    w_state_nxt = c_st_drop;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_state_nxt = c_st_hdr;
                    w_cnt_nxt   = 5'd1;
                end
            end
        end
    end

    assign w_hdr_word = w_start || (w_acc && (r_state == c_st_hdr));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= 5'd0;
            r_rem       <= 16'd0;
            r_first     <= 1'b0;
            r_uc        <= 1'b0;
            r_bc        <= 1'b0;
            r_csum      <= 16'd0;
            r_sip_tmp   <= 32'd0;
            r_sport_tmp <= 16'd0;
            r_udp_len   <= 16'd0;
            dout        <= 16'd0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            dout_vld    <= 1'b0;
            dout_mty    <= 1'b0;
            dout_err    <= 1'b0;
            pkt_sip     <= 32'd0;
            pkt_sport   <= 16'd0;
            good_cnt    <= 16'd0;
            drop_cnt    <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_first <= w_first_nxt;
            if (w_hdr_word) begin
                r_uc   <= w_uc_nxt;
                r_bc   <= w_bc_nxt;
                r_csum <= w_csum_nxt;
                case (w_idx)
                    5'd13:   r_sip_tmp[31:16] <= din;
                    5'd14:   r_sip_tmp[15:0]  <= din;
                    5'd17:   r_sport_tmp      <= din;
                    5'd19:   r_udp_len        <= din;
                    default: ;
                endcase
            end
            // Source fields are staged and only published once the header has
            // fully passed, so they stay put for the whole payload.
            if (w_latch_pkt) begin
                pkt_sip   <= r_sip_tmp;
                pkt_sport <= r_sport_tmp;
            end
            dout_vld <= w_ovld;
            dout_sop <= w_osop;
            dout_eop <= w_oeop;
            dout_mty <= w_omty;
            dout_err <= w_oerr;
            if (w_ovld) begin
                dout <= w_odata;
            end
            good_cnt <= good_cnt + {15'd0, w_good_inc};
            drop_cnt <= drop_cnt + {15'd0, w_drop_abort} + {15'd0, w_drop_start};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_unpack
//  Purpose  : Self-checking bench for rx_unpack. Frames are built by the
//             bench, expected payload words go to a scoreboard queue and are
//             compared as the DUT emits them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_unpack;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        mty;
        logic        err;
    } exp_t;

    localparam logic [47:0] c_mac   = 48'h0011_2233_4455;
    localparam logic [47:0] c_bcast = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] c_ip    = 32'hC0A8_0001;
    localparam logic [15:0] c_port  = 16'h1234;
    localparam logic [31:0] c_sip   = 32'h0A00_0005;
    localparam logic [15:0] c_sport = 16'hABCD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_sop, din_eop, din_vld, din_mty;
    logic        din_rdy;
    logic [15:0] dout;
    logic        dout_sop, dout_eop, dout_vld, dout_mty, dout_err;
    logic        dout_rdy;
    logic [31:0] pkt_sip;
    logic [15:0] pkt_sport;
    logic [15:0] good_cnt, drop_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_good = 0;
    int          exp_drop = 0;
    exp_t        sb[$];
    logic [15:0] frm[$];

    rx_unpack #(.BCAST_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mac_l (c_mac),
        .cfg_ip    (c_ip),
        .cfg_port  (c_port),
        .din       (din),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
        .din_vld   (din_vld),
        .din_mty   (din_mty),
        .din_rdy   (din_rdy),
        .dout      (dout),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .dout_vld  (dout_vld),
        .dout_mty  (dout_mty),
        .dout_err  (dout_err),
        .dout_rdy  (dout_rdy),
        .pkt_sip   (pkt_sip),
        .pkt_sport (pkt_sport),
        .good_cnt  (good_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pb(input int k);
        return 8'((k + 1) * 17);
    endfunction

    function automatic exp_t ex(input logic [15:0] d, input logic sop, input logic eop,
                                input logic mty, input logic err);
        exp_t e;
        e.d = d; e.sop = sop; e.eop = eop; e.mty = mty; e.err = err;
        return e;
    endfunction

    // Advance to the next falling edge and score any output word seen there.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (dout_vld === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: dout=%h sop=%b eop=%b mty=%b err=%b, required no output",
                         dout, dout_sop, dout_eop, dout_mty, dout_err);
            end else begin
                e = sb.pop_front();
                if ({dout, dout_sop, dout_eop, dout_mty, dout_err} !== e) begin
                    n_fail++;
                    $display("FAIL sb_word: got dout=%h sop=%b eop=%b mty=%b err=%b, required dout=%h sop=%b eop=%b mty=%b err=%b",
                             dout, dout_sop, dout_eop, dout_mty, dout_err, e.d, e.sop, e.eop, e.mty, e.err);
                end
            end
        end
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] dport,
                         input logic [15:0] ulen, input bit bad_csum, input int nbytes, input int npad);
        logic [15:0] h[21];
        logic [31:0] s;
        h[0]  = dst[47:32];  h[1] = dst[31:16];  h[2] = dst[15:0];
        h[3]  = 16'h0200;    h[4] = 16'h0000;    h[5] = 16'h0001;
        h[6]  = etype;
        h[7]  = 16'h4500;    h[8] = 16'd20 + ulen;
        h[9]  = 16'h1C46;    h[10] = 16'h4000;   h[11] = 16'h4011;
        h[12] = 16'h0000;
        h[13] = c_sip[31:16]; h[14] = c_sip[15:0];
        h[15] = c_ip[31:16];  h[16] = c_ip[15:0];
        h[17] = c_sport;      h[18] = dport;
        h[19] = ulen;         h[20] = 16'h0000;
        s = 32'd0;
        for (int k = 7; k <= 16; k++) s = s + {16'd0, h[k]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        h[12] = ~s[15:0] ^ (bad_csum ? 16'h0001 : 16'h0000);
        frm.delete();
        for (int k = 0; k < 21; k++) frm.push_back(h[k]);
        for (int k = 0; k < nbytes; k += 2)
            frm.push_back({pb(k), (k + 1 < nbytes) ? pb(k + 1) : 8'h00});
        for (int k = 0; k < npad; k++) frm.push_back(16'h0000);
    endtask

    // Sends frm; optionally holds dout_rdy low for 5 cycles at word stall_idx.
    task automatic send(input bit with_eop, input bit last_mty, input int stall_idx);
        int waitc;
        for (int i = 0; i < frm.size(); i++) begin
            step();
            din     = frm[i];
            din_vld = 1'b1;
            din_sop = (i == 0);
            din_eop = with_eop && (i == frm.size() - 1);
            din_mty = din_eop && last_mty;
            if (i == stall_idx) begin
                dout_rdy = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    n_tests++;
                    if (din_rdy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_din_rdy: din_rdy=%b, required 0", din_rdy);
                    end
                    step();
                end
                dout_rdy = 1'b1;
            end
            #1;
            waitc = 0;
            while (din_rdy !== 1'b1 && waitc < 50) begin
                step();
                #1;
                waitc++;
            end
            if (waitc == 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: din_rdy=%b, required 1 within 50 cycles", din_rdy);
            end
        end
        step();
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = 1'b0;
    endtask

    task automatic drain_and_count(input string name);
        repeat (4) step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: %0d words outstanding, required 0", name, sb.size());
            sb.delete();
        end
        n_tests++;
        if (good_cnt !== 16'(exp_good)) begin
            n_fail++;
            $display("FAIL %s_good_cnt: got %0d, required %0d", name, good_cnt, exp_good);
        end
        n_tests++;
        if (drop_cnt !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL %s_drop_cnt: got %0d, required %0d", name, drop_cnt, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 16'h0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = 1'b0;
        dout_rdy = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_tests++;
        if ({dout_vld, dout_sop, dout_eop, dout_mty, dout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000", {dout_vld, dout_sop, dout_eop, dout_mty, dout_err});
        end
        n_tests++;
        if (dout !== 16'h0 || pkt_sip !== 32'h0 || pkt_sport !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: dout=%h sip=%h sport=%h, required all 0", dout, pkt_sip, pkt_sport);
        end
        n_tests++;
        if (din_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_din_rdy: got %b, required 1", din_rdy);
        end
        drain_and_count("reset");
    endtask

    task automatic test_unicast();
        // Stray words without sop in IDLE must be ignored.
        for (int i = 0; i < 3; i++) begin
            step();
            din = c_mac[47:32]; din_vld = 1'b1; din_sop = 1'b0; din_eop = (i == 2);
        end
        step();
        din_vld = 1'b0; din_eop = 1'b0;
        build(c_mac, 16'h0800, c_port, 16'd14, 1'b0, 6, 0);
        sb.push_back(ex(16'h1122, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h3344, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h5566, 1'b0, 1'b1, 1'b0, 1'b0));
        send(1'b1, 1'b0, -1);
        exp_good++;
        drain_and_count("unicast");
        n_tests++;
        if (pkt_sip !== c_sip || pkt_sport !== c_sport) begin
            n_fail++;
            $display("FAIL unicast_pkt: sip=%h sport=%h, required %h %h", pkt_sip, pkt_sport, c_sip, c_sport);
        end
    endtask

    task automatic test_pad();
        build(c_mac, 16'h0800, c_port, 16'd9, 1'b0, 1, 23);
        sb.push_back(ex(16'h1100, 1'b1, 1'b1, 1'b1, 1'b0));
        send(1'b1, 1'b0, -1);
        exp_good++;
        drain_and_count("pad");
    endtask

    task automatic test_drops();
        build(c_mac, 16'h0800, 16'h4321, 16'd14, 1'b0, 6, 0);
        send(1'b1, 1'b0, -1);
        build(c_mac, 16'h0806, c_port, 16'd14, 1'b0, 6, 0);
        send(1'b1, 1'b0, -1);
        build(c_mac, 16'h0800, c_port, 16'd14, 1'b1, 6, 0);
        send(1'b1, 1'b0, -1);
        exp_drop += 3;
        drain_and_count("drops");
    endtask

    task automatic test_broadcast();
        build(c_bcast, 16'h0800, c_port, 16'd12, 1'b0, 4, 0);
        sb.push_back(ex(16'h1122, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h3344, 1'b0, 1'b1, 1'b0, 1'b0));
        send(1'b1, 1'b0, -1);
        exp_good++;
        drain_and_count("bcast");
    endtask

    task automatic test_hdr_eop();
        build(c_mac, 16'h0800, c_port, 16'd14, 1'b0, 6, 0);
        while (frm.size() > 11) void'(frm.pop_back());
        send(1'b1, 1'b0, -1);
        exp_drop++;
        drain_and_count("hdr_eop");
    endtask

    task automatic test_backpressure();
        build(c_mac, 16'h0800, c_port, 16'd24, 1'b0, 16, 0);
        for (int k = 0; k < 8; k++)
            sb.push_back(ex({pb(2 * k), pb(2 * k + 1)}, k == 0, k == 7, 1'b0, 1'b0));
        send(1'b1, 1'b0, 24);
        exp_good++;
        drain_and_count("bp");
    endtask

    task automatic test_truncate();
        build(c_mac, 16'h0800, c_port, 16'd20, 1'b0, 12, 0);
        while (frm.size() > 23) void'(frm.pop_back());
        sb.push_back(ex(16'h1122, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h3344, 1'b0, 1'b1, 1'b1, 1'b1));
        send(1'b1, 1'b1, -1);
        exp_drop++;
        drain_and_count("trunc");
    endtask

    task automatic test_back_to_back();
        build(c_mac, 16'h0800, c_port, 16'd20, 1'b0, 12, 0);
        while (frm.size() > 23) void'(frm.pop_back());
        sb.push_back(ex(16'h1122, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h3344, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1));
        send(1'b0, 1'b0, -1);
        build(c_mac, 16'h0800, c_port, 16'd14, 1'b0, 6, 0);
        sb.push_back(ex(16'h1122, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h3344, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h5566, 1'b0, 1'b1, 1'b0, 1'b0));
        send(1'b1, 1'b0, -1);
        exp_drop++;
        exp_good++;
        drain_and_count("b2b");
    endtask

    task automatic test_reset_midframe();
        build(c_mac, 16'h0800, c_port, 16'd14, 1'b0, 6, 0);
        while (frm.size() > 10) void'(frm.pop_back());
        send(1'b0, 1'b0, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_good = 0;
        exp_drop = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            din = 16'h0800; din_vld = 1'b1; din_sop = 1'b0; din_eop = (i == 3);
        end
        step();
        din_vld = 1'b0; din_eop = 1'b0;
        build(c_mac, 16'h0800, c_port, 16'd14, 1'b0, 6, 0);
        sb.push_back(ex(16'h1122, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h3344, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(16'h5566, 1'b0, 1'b1, 1'b0, 1'b0));
        send(1'b1, 1'b0, -1);
        exp_good++;
        drain_and_count("rst_mid");
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_pad();
        test_drops();
        test_broadcast();
        test_hdr_eop();
        test_backpressure();
        test_truncate();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
